// File: rtl/universal_register_pkg.sv
// Shared encodings for the universal register: operation modes and sequencer states.
package universal_register_pkg;

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_LOAD  = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_SHR   = 3'b011;
    localparam logic [2:0] MODE_ROTL  = 3'b100;
    localparam logic [2:0] MODE_ROTR  = 3'b101;
    localparam logic [2:0] MODE_CLR   = 3'b110;
    localparam logic [2:0] MODE_HOLD2 = 3'b111;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    // Only the four shift/rotate modes are worth repeating as a multi-step run.
    function automatic logic isShiftMode(input logic [2:0] m);
        return (m == MODE_SHL) || (m == MODE_SHR) ||
               (m == MODE_ROTL) || (m == MODE_ROTR);
    endfunction

endpackage

// File: rtl/ureg_step.sv
// Combinational one-step next value of the universal register for a given mode.
module ureg_step
    import universal_register_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic [2:0]       i_mode,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_sinL,
    input  logic             i_sinR,
    output logic [WIDTH-1:0] o_next
);

    always_comb begin
        o_next = i_q;
        case (i_mode)
            MODE_LOAD: o_next = i_d;
            MODE_SHL:  o_next = {i_q[WIDTH-2:0], i_sinR};
            MODE_SHR:  o_next = {i_sinL, i_q[WIDTH-1:1]};
            MODE_ROTL: o_next = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
            MODE_ROTR: o_next = {i_q[0], i_q[WIDTH-1:1]};
            MODE_CLR:  o_next = '0;
            default:   o_next = i_q;
        endcase
    end

endmodule

// File: rtl/universal_register.sv
// WIDTH-bit universal register with single-step ops and a multi-step shift/rotate
// sequencer; all state changes on the falling edge of clk.
module universal_register
    import universal_register_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic [CNT_W-1:0] amt,
    input  logic             start,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] MAX_STEPS = CNT_W'(WIDTH);

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_latchedMode;
    logic             r_busy;
    logic             r_done;

    logic [2:0]       w_stepMode;
    logic [WIDTH-1:0] w_next;
    logic [CNT_W-1:0] w_amtClamped;

    // In RUN the step unit must see the captured mode, not whatever is on the pins.
    assign w_stepMode   = (r_state == ST_RUN) ? r_latchedMode : mode;
    assign w_amtClamped = (amt > MAX_STEPS) ? MAX_STEPS : amt;

    ureg_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_q    (r_q),
        .i_mode (w_stepMode),
        .i_d    (d),
        .i_sinL (sin_l),
        .i_sinR (sin_r),
        .o_next (w_next)
    );

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_q           <= '0;
            r_cnt         <= '0;
            r_latchedMode <= MODE_HOLD;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (isShiftMode(mode) && (amt != '0)) begin
                            r_latchedMode <= mode;
                            r_cnt         <= w_amtClamped;
                            r_state       <= ST_RUN;
                            r_busy        <= 1'b1;
                        end else begin
                            r_q    <= w_next;
                            r_done <= 1'b1;
                        end
                    end else if (en) begin
                        r_q <= w_next;
                    end
                end
                ST_RUN: begin
                    r_q   <= w_next;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign q      = r_q;
    assign sout_l = r_q[WIDTH-1];
    assign sout_r = r_q[0];
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_universal_register.sv
// Directed bench for universal_register: a WIDTH=8 instance driven from a vector
// table plus multi-cycle sequences, and a WIDTH=32 instance for the wide rotate.
module tb_universal_register;
    import universal_register_pkg::*;

    logic       clk;
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sin_l;
    logic       sin_r;
    logic [3:0] amt;
    logic       start;
    logic [7:0] q;
    logic       sout_l;
    logic       sout_r;
    logic       busy;
    logic       done;

    logic        en32;
    logic [2:0]  mode32;
    logic [31:0] d32;
    logic [5:0]  amt32;
    logic        start32;
    logic [31:0] q32;
    logic        soutL32;
    logic        soutR32;
    logic        busy32;
    logic        done32;

    int nChecks = 0;
    int nPass   = 0;

    universal_register #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
        .sin_l(sin_l), .sin_r(sin_r), .amt(amt), .start(start),
        .q(q), .sout_l(sout_l), .sout_r(sout_r), .busy(busy), .done(done)
    );

    universal_register #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .en(en32), .mode(mode32), .d(d32),
        .sin_l(1'b0), .sin_r(1'b0), .amt(amt32), .start(start32),
        .q(q32), .sout_l(soutL32), .sout_r(soutR32), .busy(busy32), .done(done32)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic       start;
        logic       en;
        logic [2:0] mode;
        logic [7:0] d;
        logic       sinL;
        logic       sinR;
        logic [3:0] amt;
        logic [7:0] expQ;
        logic       expBusy;
        logic       expDone;
    } vec_t;

    vec_t vecs[16];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic applyStimulus(input logic st, input logic e, input logic [2:0] m,
                                 input logic [7:0] dv, input logic sl, input logic sr,
                                 input logic [3:0] a);
        start = st; en = e; mode = m; d = dv; sin_l = sl; sin_r = sr; amt = a;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic checkState(input string name, input logic [7:0] eq, input logic eb, input logic ed);
        checkOutput({name, ".q"}, 32'(q), 32'(eq));
        checkOutput({name, ".busy"}, 32'(busy), 32'(eb));
        checkOutput({name, ".done"}, 32'(done), 32'(ed));
    endtask

    initial begin
        logic [7:0] expQ;

        vecs[0]  = '{1'b0, 1'b1, MODE_LOAD,  8'hA5, 1'b0, 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, MODE_SHL,   8'h00, 1'b0, 1'b1, 4'd0, 8'h4B, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, MODE_SHR,   8'h00, 1'b0, 1'b0, 4'd0, 8'h25, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, MODE_ROTL,  8'h00, 1'b0, 1'b0, 4'd0, 8'h4A, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, MODE_ROTR,  8'h00, 1'b0, 1'b0, 4'd0, 8'h25, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, MODE_LOAD,  8'hA5, 1'b0, 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, MODE_ROTL,  8'h00, 1'b0, 1'b0, 4'd0, 8'h4B, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, MODE_ROTR,  8'h00, 1'b0, 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, MODE_SHR,   8'h00, 1'b1, 1'b0, 4'd0, 8'hD2, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, MODE_LOAD,  8'h00, 1'b0, 1'b0, 4'd0, 8'hD2, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, MODE_HOLD2, 8'h11, 1'b1, 1'b1, 4'd0, 8'hD2, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, MODE_HOLD,  8'h22, 1'b1, 1'b1, 4'd0, 8'hD2, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, MODE_LOAD,  8'h3C, 1'b0, 1'b0, 4'd5, 8'h3C, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b0, MODE_HOLD,  8'h00, 1'b0, 1'b0, 4'd0, 8'h3C, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, MODE_CLR,   8'hFF, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b1, MODE_CLR,   8'h00, 1'b0, 1'b0, 4'd3, 8'h00, 1'b0, 1'b1};

        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0, 4'd0);
        en32 = 1'b0; mode32 = MODE_HOLD; d32 = '0; amt32 = '0; start32 = 1'b0;
        #2;
        checkState("reset", 8'h00, 1'b0, 1'b0);
        @(posedge clk); #1 rst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].start, vecs[i].en, vecs[i].mode, vecs[i].d,
                          vecs[i].sinL, vecs[i].sinR, vecs[i].amt);
            tick();
            checkState($sformatf("vec%0d", i), vecs[i].expQ, vecs[i].expBusy, vecs[i].expDone);
            checkOutput($sformatf("vec%0d.sout_l", i), 32'(sout_l), 32'(vecs[i].expQ[7]));
            checkOutput($sformatf("vec%0d.sout_r", i), 32'(sout_r), 32'(vecs[i].expQ[0]));
        end

        // Multi-step rotr by 3 with en/mode/start noise while running.
        applyStimulus(1'b0, 1'b1, MODE_LOAD, 8'h81, 1'b0, 1'b0, 4'd0);
        tick();
        applyStimulus(1'b1, 1'b0, MODE_ROTR, 8'h00, 1'b0, 1'b0, 4'd3);
        tick();
        checkState("rotr.E0", 8'h81, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, MODE_LOAD, 8'hFF, 1'b1, 1'b1, 4'd7);
        tick();
        checkState("rotr.E1", 8'hC0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, MODE_SHL, 8'hFF, 1'b1, 1'b1, 4'd1);
        tick();
        checkState("rotr.E2", 8'h60, 1'b1, 1'b0);
        tick();
        checkState("rotr.E3", 8'h30, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0, 4'd0);
        tick();
        checkState("rotr.E4", 8'h30, 1'b0, 1'b0);

        // Clamp: amt=12 on an 8-bit register runs exactly 8 steps.
        applyStimulus(1'b0, 1'b1, MODE_LOAD, 8'hFF, 1'b0, 1'b0, 4'd0);
        tick();
        applyStimulus(1'b1, 1'b0, MODE_SHL, 8'h00, 1'b0, 1'b0, 4'd12);
        tick();
        checkState("clamp.E0", 8'hFF, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0, 4'd0);
        expQ = 8'hFF;
        for (int k = 1; k <= 8; k++) begin
            tick();
            expQ = expQ << 1;
            checkState($sformatf("clamp.E%0d", k), expQ, (k < 8), (k == 8));
        end
        tick();
        checkState("clamp.E9", 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, MODE_SHL, 8'h00, 1'b0, 1'b0, 4'd0);
        tick();
        checkState("amt0.E0", 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0, 4'd0);
        tick();
        checkState("amt0.E1", 8'h00, 1'b0, 1'b0);

        // Abort a shr run with async reset between E2 and E3.
        applyStimulus(1'b0, 1'b1, MODE_LOAD, 8'h5A, 1'b0, 1'b0, 4'd0);
        tick();
        applyStimulus(1'b1, 1'b0, MODE_SHR, 8'h00, 1'b1, 1'b0, 4'd6);
        tick();
        applyStimulus(1'b0, 1'b0, MODE_HOLD, 8'h00, 1'b1, 1'b0, 4'd0);
        tick();
        checkState("abort.E1", 8'hAD, 1'b1, 1'b0);
        tick();
        checkState("abort.E2", 8'hD6, 1'b1, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        #1;
        checkState("abort.rst", 8'h00, 1'b0, 1'b0);
        tick();
        checkState("abort.held", 8'h00, 1'b0, 1'b0);
        @(posedge clk); #1 rst = 1'b1;
        applyStimulus(1'b0, 1'b1, MODE_LOAD, 8'h81, 1'b0, 1'b0, 4'd0);
        tick();
        checkState("restart.load", 8'h81, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, MODE_ROTL, 8'h00, 1'b0, 1'b0, 4'd2);
        tick();
        applyStimulus(1'b0, 1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0, 4'd0);
        tick();
        checkState("restart.E1", 8'h03, 1'b1, 1'b0);
        tick();
        checkState("restart.E2", 8'h06, 1'b0, 1'b1);

        // Wide instance: rotl by 16 swaps the half-words.
        en32 = 1'b1; mode32 = MODE_LOAD; d32 = 32'hDEADBEEF;
        tick();
        checkOutput("w32.load", q32, 32'hDEADBEEF);
        en32 = 1'b0; start32 = 1'b1; mode32 = MODE_ROTL; amt32 = 6'd16;
        tick();
        start32 = 1'b0; mode32 = MODE_HOLD;
        checkOutput("w32.E0.busy", 32'(busy32), 32'd1);
        for (int k = 1; k <= 16; k++) begin
            tick();
            checkOutput($sformatf("w32.E%0d.busy", k), 32'(busy32), 32'((k < 16) ? 1 : 0));
            checkOutput($sformatf("w32.E%0d.done", k), 32'(done32), 32'((k == 16) ? 1 : 0));
        end
        checkOutput("w32.q", q32, 32'hBEEFDEAD);
        checkOutput("w32.sout_l", 32'(soutL32), 32'd1);
        checkOutput("w32.sout_r", 32'(soutR32), 32'd1);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
